// File: rtl/bitstream_slot_mgr.sv
// Bitstream slot manager: allocates granule-aligned DDR slots per bitstream ID,
// tracks store completion and issues DMA load commands for stored bitstreams.
module bitstream_slot_mgr #(
  parameter int unsigned     ADDR_WIDTH = 34,
  parameter int unsigned     ID_WIDTH   = 4,
  parameter longint unsigned MEM_BYTES  = 2**30,
  parameter int unsigned     ALIGN_LOG2 = 12
) (
  input  logic                  s_axis_clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_func,
  input  logic [ID_WIDTH-1:0]   req_id,
  input  logic [31:0]           req_size,
  input  logic                  req_size_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_addr_valid,
  input  logic                  store_done,
  output logic                  dma_cmd_valid,
  input  logic                  dma_cmd_ready,
  output logic [ADDR_WIDTH-1:0] dma_cmd_addr,
  output logic [31:0]           dma_cmd_len,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ID_WIDTH;
  // Wide enough for a 32-bit size rounded up plus a full address, so no sum can wrap.
  localparam int unsigned SW    = (ADDR_WIDTH + 1 > 34) ? ADDR_WIDTH + 1 : 34;
  localparam logic [SW:0]   MEM_L = (SW+1)'(MEM_BYTES);
  localparam logic [SW-1:0] GMASK = SW'((64'd1 << ALIGN_LOG2) - 64'd1);

  localparam logic [1:0] FN_STORE = 2'b00;
  localparam logic [1:0] FN_LOAD  = 2'b01;
  localparam logic [1:0] FN_CLEAR = 2'b10;

  localparam logic [1:0] E_BAD_SIZE = 2'b00;
  localparam logic [1:0] E_NO_SPACE = 2'b01;
  localparam logic [1:0] E_DUP_ID   = 2'b10;
  localparam logic [1:0] E_NOT_FND  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_ALLOC, S_WR_ACTIVE, S_DMA_ISSUE, S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic [1:0]            func_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [31:0]           size_q;
  logic                  szv_q;

  logic [DEPTH-1:0]      valid_q, pending_q;
  logic [ADDR_WIDTH-1:0] base_q [DEPTH];
  logic [31:0]           len_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] next_free_q;

  logic [ADDR_WIDTH-1:0] wr_addr_q, dma_addr_q;
  logic [31:0]           dma_len_q;
  logic [1:0]            err_code_q, err_d;

  logic                  take_req, do_alloc, do_commit, do_dma, do_clear;
  logic                  ent_valid, ent_pending, fits;
  logic [SW-1:0]         rsize, nf_ext;

  assign ent_valid   = valid_q[id_q];
  assign ent_pending = pending_q[id_q];
  assign nf_ext      = SW'(next_free_q);
  assign rsize       = (SW'(size_q) + GMASK) & ~GMASK;
  assign fits        = ({1'b0, nf_ext} + {1'b0, rsize}) <= MEM_L;

  assign req_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign wr_addr_valid = (state_q == S_ALLOC);
  assign dma_cmd_valid = (state_q == S_DMA_ISSUE);
  assign err_valid     = (state_q == S_ERROR);
  assign wr_addr       = wr_addr_q;
  assign dma_cmd_addr  = dma_addr_q;
  assign dma_cmd_len   = dma_len_q;
  assign err_code      = err_code_q;

  always_ff @(posedge s_axis_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_code_q;
    take_req  = 1'b0;
    do_alloc  = 1'b0;
    do_commit = 1'b0;
    do_dma    = 1'b0;
    do_clear  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          take_req = 1'b1;
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        case (func_q)
          FN_STORE: begin
            if (!szv_q || size_q == '0) begin
              err_d   = E_BAD_SIZE;
              state_d = S_ERROR;
            end else if (ent_valid || ent_pending) begin
              err_d   = E_DUP_ID;
              state_d = S_ERROR;
            end else if (!fits) begin
              err_d   = E_NO_SPACE;
              state_d = S_ERROR;
            end else begin
              do_alloc = 1'b1;
              state_d  = S_ALLOC;
            end
          end
          FN_LOAD: begin
            if (!ent_valid || ent_pending) begin
              err_d   = E_NOT_FND;
              state_d = S_ERROR;
            end else begin
              do_dma  = 1'b1;
              state_d = S_DMA_ISSUE;
            end
          end
          FN_CLEAR: begin
            do_clear = 1'b1;
            state_d  = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_ALLOC: state_d = S_WR_ACTIVE;
      S_WR_ACTIVE: begin
        if (store_done) begin
          do_commit = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DMA_ISSUE: begin
        if (dma_cmd_ready) state_d = S_IDLE;
      end
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_clk) begin
    if (rst) begin
      func_q      <= '0;
      id_q        <= '0;
      size_q      <= '0;
      szv_q       <= 1'b0;
      valid_q     <= '0;
      pending_q   <= '0;
      next_free_q <= '0;
      wr_addr_q   <= '0;
      dma_addr_q  <= '0;
      dma_len_q   <= '0;
      err_code_q  <= '0;
    end else begin
      err_code_q <= err_d;
      if (take_req) begin
        func_q <= req_func;
        id_q   <= req_id;
        size_q <= req_size;
        szv_q  <= req_size_valid;
      end
      if (do_alloc) begin
        pending_q[id_q] <= 1'b1;
        base_q[id_q]    <= next_free_q;
        len_q[id_q]     <= size_q;
        next_free_q     <= ADDR_WIDTH'(nf_ext + rsize);
        wr_addr_q       <= next_free_q;
      end
      if (do_commit) begin
        valid_q[id_q]   <= 1'b1;
        pending_q[id_q] <= 1'b0;
      end
      if (do_dma) begin
        dma_addr_q <= base_q[id_q];
        dma_len_q  <= len_q[id_q];
      end
      if (do_clear) begin
        valid_q     <= '0;
        pending_q   <= '0;
        next_free_q <= '0;
      end
    end
  end

endmodule
